// File: rtl/lpc_record_serializer.sv
// LPC snoop record FIFO + MSB-first byte serializer with overflow tracking.
// Define LPC_SER_SYNC_EN to prefix each record with sync byte 8'hA5.
module lpc_record_serializer #(
  parameter int FIFO_AW = 4,
  parameter int REC_W   = 32
) (
  input  logic               clk_i,
  input  logic               nrst_i,
  input  logic [REC_W-1:0]   tdata_i,
  input  logic               ready_i,
  output logic [7:0]         m_data_o,
  output logic               m_valid_o,
  input  logic               m_ready_i,
  output logic [FIFO_AW:0]   fifo_level_o,
  output logic               overflow_o,
  output logic [7:0]         drop_cnt_o,
  input  logic               clear_ovf_i
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   LVL_ONE  = 1;
  localparam logic [FIFO_AW:0]   LVL_FULL = DEPTH[FIFO_AW:0];
  localparam logic [FIFO_AW-1:0] PTR_ONE  = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SY,
    S_B3,
    S_B2,
    S_B1,
    S_B0
  } state_e;

`ifdef LPC_SER_SYNC_EN
  localparam state_e S_FIRST = S_SY;
`else
  localparam state_e S_FIRST = S_B3;
`endif

  logic               ready_q;
  logic [FIFO_AW-1:0] wr_q, rd_q;
  logic [FIFO_AW:0]   level_q, level_d;
  logic [REC_W-1:0]   mem_q [DEPTH];
  logic [REC_W-1:0]   sr_q, sr_d;
  state_e             state_q, state_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         cnt_q, cnt_d;

  logic push, full, empty, pop;
  logic accept, drop, valid, hs;

  assign push   = ready_i & ~ready_q;
  assign full   = (level_q == LVL_FULL);
  assign empty  = (level_q == '0);
  assign valid  = (state_q != S_IDLE);
  assign hs     = valid & m_ready_i;
  // a full FIFO still takes a record when the serializer pops that edge
  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    sr_d    = sr_q;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_FIRST;
        end
      end
      S_SY: if (hs) state_d = S_B3;
      S_B3: if (hs) state_d = S_B2;
      S_B2: if (hs) state_d = S_B1;
      S_B1: if (hs) state_d = S_B0;
      S_B0: begin
        if (hs) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = S_FIRST;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (pop) begin
      sr_d = mem_q[rd_q];
    end else if (hs && state_q != S_SY) begin
      sr_d = sr_q << 8;
    end
  end

  always_comb begin
    level_d = level_q;
    if (accept && !pop) begin
      level_d = level_q + LVL_ONE;
    end else if (pop && !accept) begin
      level_d = level_q - LVL_ONE;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    if (clear_ovf_i) begin
      ovf_d = 1'b0;
      cnt_d = 8'h00;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) mem_q[wr_q] <= tdata_i;
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      ready_q <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      sr_q    <= '0;
      state_q <= S_IDLE;
      ovf_q   <= 1'b0;
      cnt_q   <= 8'h00;
    end else begin
      ready_q <= ready_i;
      if (accept) wr_q <= wr_q + PTR_ONE;
      if (pop)    rd_q <= rd_q + PTR_ONE;
      level_q <= level_d;
      sr_q    <= sr_d;
      state_q <= state_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign m_valid_o    = valid;
  assign m_data_o     = !valid ? 8'h00 :
                        (state_q == S_SY) ? 8'hA5 :
                        sr_q[REC_W-1 -: 8];
  assign fifo_level_o = level_q;
  assign overflow_o   = ovf_q;
  assign drop_cnt_o   = cnt_q;

endmodule

// File: tb/tb_lpc_record_serializer.sv
// Scoreboard bench for lpc_record_serializer: directed scenarios plus
// randomized strobe/backpressure traffic against a record-queue model.
module tb_lpc_record_serializer;

`ifdef LPC_SER_SYNC_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] tdata;
  logic        ready;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic [4:0]  level;
  logic        ovf;
  logic [7:0]  dcnt;
  logic        clear;

  always #5 clk = ~clk;

  lpc_record_serializer #(.FIFO_AW(4), .REC_W(32)) dut (
    .clk_i       (clk),
    .nrst_i      (nrst),
    .tdata_i     (tdata),
    .ready_i     (ready),
    .m_data_o    (m_data),
    .m_valid_o   (m_valid),
    .m_ready_i   (m_ready),
    .fifo_level_o(level),
    .overflow_o  (ovf),
    .drop_cnt_o  (dcnt),
    .clear_ovf_i (clear)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // model: records waiting in the FIFO, bytes still owed to the consumer,
  // bytes left of the record being sent, and the overflow bookkeeping
  logic [31:0] mq[$];
  logic [7:0]  exp_q[$];
  int          cur_left = 0;
  bit          rprev = 0;
  bit          m_ovf = 0;
  int          m_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    bit hs, push, full, pop, acc;
    if (!nrst) begin
      chk("rst_valid", 64'(m_valid), 64'd0);
      chk("rst_data",  64'(m_data),  64'd0);
      chk("rst_level", 64'(level),   64'd0);
      chk("rst_ovf",   64'(ovf),     64'd0);
      chk("rst_cnt",   64'(dcnt),    64'd0);
      mq.delete();
      exp_q.delete();
      cur_left = 0;
      rprev = 0;
      m_ovf = 0;
      m_cnt = 0;
    end else begin
      chk("valid", 64'(m_valid), 64'(cur_left > 0));
      chk("level", 64'(level),   64'(mq.size()));
      chk("ovf",   64'(ovf),     64'(m_ovf));
      chk("cnt",   64'(dcnt),    64'(m_cnt));
      if (cur_left > 0) begin
        if (exp_q.size() == 0) chk("data_unexpected", 64'(m_data), 64'hFFFF);
        else chk("data", 64'(m_data), 64'(exp_q[0]));
      end
      hs = (cur_left > 0) && m_ready;
      if (hs && exp_q.size() > 0) void'(exp_q.pop_front());
      push  = ready && !rprev;
      rprev = ready;
      full  = (mq.size() == 16);
      pop   = (mq.size() > 0) && (cur_left == 0 || (cur_left == 1 && hs));
      acc   = push && (!full || pop);
      if (pop) begin
        void'(mq.pop_front());
        cur_left = NB;
      end else if (hs) begin
        cur_left--;
      end
      if (clear) begin
        m_ovf = 0;
        m_cnt = 0;
      end else if (push && !acc) begin
        m_ovf = 1;
        if (m_cnt < 255) m_cnt++;
      end
      if (acc) begin
        mq.push_back(tdata);
`ifdef LPC_SER_SYNC_EN
        exp_q.push_back(8'hA5);
`endif
        for (int i = 3; i >= 0; i--) exp_q.push_back(tdata[8*i +: 8]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic strobe(input logic [31:0] d, input int hold);
    tdata = d;
    ready = 1'b1;
    repeat (hold) cyc();
    ready = 1'b0;
    cyc();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    m_ready = 1'b1;
    while (exp_q.size() > 0 && n < budget) begin
      cyc();
      n++;
    end
    repeat (2) cyc();
    chk("drain_done", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst    = 1'b0;
    ready   = 1'b0;
    m_ready = 1'b0;
    clear   = 1'b0;
    tdata   = '0;
    repeat (3) cyc();
    nrst = 1'b1;
    cyc();

    m_ready = 1'b1;
    strobe(32'h0123_4501, 1);
    repeat (8) cyc();
    chk("single_level", 64'(level), 64'd0);

    strobe(32'h0000_0FF3, 2);
    repeat (8) cyc();
    chk("hold_level", 64'(level), 64'd0);
    chk("hold_valid", 64'(m_valid), 64'd0);

    // record 0 moves straight into the shift register, so 17 strobes fill it
    m_ready = 1'b0;
    for (int k = 0; k < 17; k++) strobe(32'h1000_0000 | k, 1);
    chk("fill_level", 64'(level), 64'd16);
    chk("fill_cnt",   64'(dcnt),  64'd0);
    strobe(32'h1000_0011, 1);
    chk("ovf_level", 64'(level), 64'd16);
    chk("ovf_flag",  64'(ovf),   64'd1);
    chk("ovf_cnt",   64'(dcnt),  64'd1);

    m_ready = 1'b1;
    repeat (NB - 1) cyc();
    tdata = 32'h2222_3333;
    ready = 1'b1;
    cyc();
    ready = 1'b0;
    chk("coinc_level", 64'(level), 64'd16);
    chk("coinc_cnt",   64'(dcnt),  64'd1);
    drain(300);

    m_ready = 1'b0;
    for (int k = 0; k < 320; k++) strobe($urandom, 1);
    chk("sat_cnt", 64'(dcnt), 64'hFF);
    chk("sat_ovf", 64'(ovf),  64'd1);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("clr_ovf", 64'(ovf),  64'd0);
    chk("clr_cnt", 64'(dcnt), 64'd0);
    tdata = 32'h5555_AAAA;
    ready = 1'b1;
    clear = 1'b1;
    cyc();
    ready = 1'b0;
    clear = 1'b0;
    cyc();
    chk("clrdrop_ovf", 64'(ovf),  64'd0);
    chk("clrdrop_cnt", 64'(dcnt), 64'd0);
    drain(300);

    m_ready = 1'b1;
    strobe(32'hCAFE_BABE, 1);
    repeat (NB - 3) cyc();
    nrst = 1'b0;
    #1;
    chk("midrst_valid", 64'(m_valid), 64'd0);
    chk("midrst_level", 64'(level),   64'd0);
    cyc();
    nrst = 1'b1;
    cyc();
    strobe(32'h89AB_CDEF, 1);
    drain(50);

    for (int ph = 0; ph < 6; ph++) begin
      for (int c = 0; c < 500; c++) begin
        if (!ready && $urandom_range(3) == 0) begin
          tdata = $urandom;
          ready = 1'b1;
        end else if (ready && $urandom_range(1) == 0) begin
          ready = 1'b0;
        end
        if (ph % 2 == 1) m_ready = ($urandom_range(3) == 0);
        else m_ready = ($urandom_range(3) != 0);
        clear = ($urandom_range(63) == 0);
        cyc();
      end
    end
    ready = 1'b0;
    clear = 1'b0;
    cyc();
    drain(2000);
    chk("final_level", 64'(level), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
